// File: rtl/regfile_port_scheduler_pkg.sv
// Shared types for the register-file port scheduler: data/address widths and the
// one-slot command that the scheduler presents to the register file each cycle.
package rf_sched_pkg;
  localparam int XLEN = 32;
  localparam int AW   = 5;

  typedef enum logic [1:0] {CMD_NOP, CMD_READ, CMD_WRITE} cmd_e;

  // For writes, a1 carries the destination register and data the write value.
  typedef struct packed {
    cmd_e            op;
    logic [AW-1:0]   a1;
    logic [AW-1:0]   a2;
    logic [XLEN-1:0] data;
  } cmd_t;

  localparam cmd_t CMD_IDLE = '{op: CMD_NOP, a1: '0, a2: '0, data: '0};
endpackage

// File: rtl/regfile_port_scheduler_if.sv
// Requester-side bundle: N_WR valid/ready write sources, one valid/ready reader and
// its read-result return path.
interface regfile_port_scheduler_if
  import rf_sched_pkg::*;
#(
  parameter int N_WR = 3
);
  logic [N_WR-1:0]      wr_valid;
  logic [N_WR*AW-1:0]   wr_addr;
  logic [N_WR*XLEN-1:0] wr_data;
  logic [N_WR-1:0]      wr_ready;
  logic                 rd_valid;
  logic [AW-1:0]        rd_a1;
  logic [AW-1:0]        rd_a2;
  logic                 rd_ready;
  logic                 rd_rvalid;
  logic [XLEN-1:0]      rd_data1;
  logic [XLEN-1:0]      rd_data2;

  modport master (
    output wr_valid, wr_addr, wr_data, rd_valid, rd_a1, rd_a2,
    input  wr_ready, rd_ready, rd_rvalid, rd_data1, rd_data2
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, rd_valid, rd_a1, rd_a2,
    output wr_ready, rd_ready, rd_rvalid, rd_data1, rd_data2
  );
endinterface

// File: rtl/regfile_port_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
// Returns one-hot gnt (0 when no request) and its index.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);
  logic          found;
  logic [IW-1:0] cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < N; i++) begin
      cand = IW'((int'(ptr) + i) % N);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end
endmodule

// File: rtl/regfile_port_scheduler.sv
// Owns the register file's single access slot: grants one read or one write per cycle and
// replays it to the register file one cycle later (read data returns combinationally then).
module regfile_port_scheduler
  import rf_sched_pkg::*;
#(
  parameter int N_WR       = 3,
  parameter int STARVE_MAX = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  regfile_port_scheduler_if.slave bus,
  output logic [AW-1:0]           o_rf_A1,
  output logic [AW-1:0]           o_rf_A2,
  output logic [AW-1:0]           o_rf_A3,
  output logic [XLEN-1:0]         o_rf_WD3,
  output logic                    o_rf_WE3,
  input  logic [XLEN-1:0]         i_rf_RD1,
  input  logic [XLEN-1:0]         i_rf_RD2,
  output logic                    o_busy
);
  localparam int IW = (N_WR > 1) ? $clog2(N_WR) : 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  cmd_t          cmd_q, cmd_d;
  logic [IW-1:0] rr_ptr, rr_next;
  logic [SW-1:0] starve_cnt;
  logic [N_WR-1:0] arb_gnt;
  logic [IW-1:0] arb_idx;
  logic          wr_pending, starved, wr_grant, rd_grant;

  rr_arbiter #(.N(N_WR), .IW(IW)) u_arb (
    .req (bus.wr_valid),
    .ptr (rr_ptr),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  // Grants are masked while in reset so nothing is accepted only to be dropped.
  always_comb begin
    wr_pending   = |bus.wr_valid;
    starved      = (starve_cnt == SW'(STARVE_MAX));
    wr_grant     = i_rst && wr_pending && (!bus.rd_valid || starved);
    rd_grant     = i_rst && bus.rd_valid && !wr_grant;
    bus.wr_ready = wr_grant ? arb_gnt : '0;
    bus.rd_ready = rd_grant;
    rr_next      = (arb_idx == IW'(N_WR - 1)) ? '0 : arb_idx + 1'b1;
    cmd_d        = CMD_IDLE;
    if (wr_grant) begin
      cmd_d.op   = CMD_WRITE;
      cmd_d.a1   = bus.wr_addr[int'(arb_idx)*AW +: AW];
      cmd_d.data = bus.wr_data[int'(arb_idx)*XLEN +: XLEN];
    end else if (rd_grant) begin
      cmd_d.op = CMD_READ;
      cmd_d.a1 = bus.rd_a1;
      cmd_d.a2 = bus.rd_a2;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      cmd_q      <= CMD_IDLE;
      rr_ptr     <= '0;
      starve_cnt <= '0;
    end else begin
      cmd_q <= cmd_d;
      if (wr_grant) rr_ptr <= rr_next;
      if (wr_grant || !wr_pending) starve_cnt <= '0;
      else if (rd_grant && !starved) starve_cnt <= starve_cnt + 1'b1;
    end
  end

  always_comb begin
    o_rf_A1       = '0;
    o_rf_A2       = '0;
    o_rf_A3       = '0;
    o_rf_WD3      = '0;
    o_rf_WE3      = 1'b0;
    bus.rd_rvalid = 1'b0;
    bus.rd_data1  = '0;
    bus.rd_data2  = '0;
    case (cmd_q.op)
      CMD_READ: begin
        o_rf_A1       = cmd_q.a1;
        o_rf_A2       = cmd_q.a2;
        bus.rd_rvalid = 1'b1;
        bus.rd_data1  = i_rf_RD1;
        bus.rd_data2  = i_rf_RD2;
      end
      CMD_WRITE: begin
        // x0 writes still occupy the slot but never assert the enable.
        o_rf_A3  = cmd_q.a1;
        o_rf_WD3 = cmd_q.data;
        o_rf_WE3 = (cmd_q.a1 != '0);
      end
      default: ;
    endcase
    o_busy = (cmd_q.op != CMD_NOP);
  end
endmodule

// File: tb/tb_regfile_port_scheduler.sv
// Bench for regfile_port_scheduler with a behavioural register file and a read-result scoreboard.
module tb_regfile_port_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_port_scheduler_if #(.N_WR(3)) bus ();

  logic [4:0]  rf_a1, rf_a2, rf_a3;
  logic [31:0] rf_wd3, rf_rd1, rf_rd2;
  logic        rf_we3, busy;

  regfile_port_scheduler #(.N_WR(3), .STARVE_MAX(4)) dut (
    .i_clk    (clk),
    .i_rst    (rst_n),
    .bus      (bus),
    .o_rf_A1  (rf_a1),
    .o_rf_A2  (rf_a2),
    .o_rf_A3  (rf_a3),
    .o_rf_WD3 (rf_wd3),
    .o_rf_WE3 (rf_we3),
    .i_rf_RD1 (rf_rd1),
    .i_rf_RD2 (rf_rd2),
    .o_busy   (busy)
  );

  // Register file: combinational read, forced to 0 while writing; write at clock edge.
  logic [31:0] rf_mem [32] = '{default: 32'h0};
  always @(posedge clk) if (rf_we3 && rf_a3 != 5'd0) rf_mem[rf_a3] <= rf_wd3;
  assign rf_rd1 = rf_we3 ? 32'h0 : rf_mem[rf_a1];
  assign rf_rd2 = rf_we3 ? 32'h0 : rf_mem[rf_a2];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference register state, updated in grant order; writes land one cycle after grant
  // so a reset in between drops them.
  logic [31:0] ref_mem [32] = '{default: 32'h0};
  logic        pend_wr = 1'b0;
  logic [4:0]  pend_a;
  logic [31:0] pend_d;
  logic        exp_rvalid = 1'b0;
  logic [63:0] sb_q [$];
  logic [63:0] sb_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      pend_wr    = 1'b0;
      exp_rvalid = 1'b0;
      sb_q.delete();
    end else begin
      chk("rvalid", bus.rd_rvalid, exp_rvalid);
      if (bus.rd_rvalid) begin
        if (sb_q.size() == 0) chk("sb_underflow", 1, 0);
        else begin
          sb_e = sb_q.pop_front();
          chk("rd_data", {bus.rd_data1, bus.rd_data2}, sb_e);
        end
      end else begin
        chk("rd_data_idle", {bus.rd_data1, bus.rd_data2}, 64'h0);
      end
      if (pend_wr && pend_a != 5'd0) ref_mem[pend_a] = pend_d;
      pend_wr    = 1'b0;
      exp_rvalid = bus.rd_valid && bus.rd_ready;
      if (exp_rvalid) sb_q.push_back({ref_mem[bus.rd_a1], ref_mem[bus.rd_a2]});
      for (int k = 0; k < 3; k++) begin
        if (bus.wr_valid[k] && bus.wr_ready[k]) begin
          pend_wr = 1'b1;
          pend_a  = bus.wr_addr[k*5 +: 5];
          pend_d  = bus.wr_data[k*32 +: 32];
        end
      end
    end
  end

  task automatic do_write(input int src, input logic [4:0] a, input logic [31:0] d);
    bit done = 0;
    bus.wr_addr[src*5 +: 5]   = a;
    bus.wr_data[src*32 +: 32] = d;
    bus.wr_valid[src]         = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (bus.wr_ready[src]) done = 1;
    end
    if (!done) chk("wr_timeout", 0, 1);
    @(posedge clk);
    #1 bus.wr_valid[src] = 1'b0;
  endtask

  task automatic do_read(input logic [4:0] a1, input logic [4:0] a2);
    bit done = 0;
    bus.rd_a1    = a1;
    bus.rd_a2    = a2;
    bus.rd_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (bus.rd_ready) done = 1;
    end
    if (!done) chk("rd_timeout", 0, 1);
    @(posedge clk);
    #1 bus.rd_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.wr_valid = '0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.rd_valid = 1'b0; bus.rd_a1 = '0; bus.rd_a2 = '0;

    // Reset state, with requests pending that must not be accepted.
    repeat (2) @(posedge clk);
    #1 bus.wr_valid = 3'b111; bus.rd_valid = 1'b1;
    #1;
    chk("rst_wr_ready", bus.wr_ready, 3'b000);
    chk("rst_rd_ready", bus.rd_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_we3", rf_we3, 0);
    chk("rst_rvalid", bus.rd_rvalid, 0);
    bus.wr_valid = '0; bus.rd_valid = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: reset while WRITE(x5, 0xAA) is in flight drops it.
    do_write(0, 5'd5, 32'hAA);
    chk("t1_inflight_we3", rf_we3, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_we3", rf_we3, 0);
    chk("t1_a3", rf_a3, 0);
    chk("t1_wd3", rf_wd3, 0);
    chk("t1_busy", busy, 0);
    @(posedge clk); @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_read(5'd5, 5'd5);
    idle(2);

    // 2: write x3 then read (3, 0).
    do_write(0, 5'd3, 32'h1234);
    do_read(5'd3, 5'd0);
    idle(2);

    // 3: all sources valid -> strict rotation, enable every cycle.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      bus.wr_addr[k*5 +: 5]   = 5'(10 + k);
      bus.wr_data[k*32 +: 32] = 32'h100 + k;
    end
    bus.wr_valid = 3'b111;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t3_gnt", bus.wr_ready, 3'b001 << (i % 3));
      chk("t3_rd_ready", bus.rd_ready, 0);
      if (i > 0) chk("t3_we3", rf_we3, 1);
    end
    @(posedge clk);
    #1 bus.wr_valid = '0;
    @(negedge clk);
    chk("t3_we3_last", rf_we3, 1);
    idle(2);

    // 4: read held against src1 -> four reads then one write, repeating.
    bus.wr_addr[1*5 +: 5]   = 5'd20;
    bus.wr_data[1*32 +: 32] = 32'hBEEF;
    bus.wr_valid[1] = 1'b1;
    bus.rd_a1 = 5'd10; bus.rd_a2 = 5'd11; bus.rd_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t4_rd_gnt", bus.rd_ready, (i % 5) != 4);
      chk("t4_wr_gnt", bus.wr_ready, ((i % 5) == 4) ? 3'b010 : 3'b000);
    end
    @(posedge clk);
    #1 bus.wr_valid = '0; bus.rd_valid = 1'b0;
    idle(2);
    do_read(5'd20, 5'd10);
    idle(2);

    // 5: write to x0 is accepted but never enabled.
    do_write(2, 5'd0, 32'hFFFF_FFFF);
    chk("t5_we3", rf_we3, 0);
    chk("t5_busy", busy, 1);
    do_read(5'd0, 5'd0);
    idle(2);

    // 6: read granted the cycle right after a write to the same register.
    do_write(0, 5'd7, 32'h55);
    do_read(5'd7, 5'd7);
    idle(3);

    chk("sb_drain", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
